// File: rtl/counter_timp_pkg.sv
// counter_timp_pkg: shared widths, limits, the HH:MM struct and the
// increment/validity helpers used by the time-of-day counter.
package counter_timp_pkg;

  localparam int ORE_W = 5;
  localparam int MIN_W = 6;

  localparam int unsigned MAX_ORE = 23;
  localparam int unsigned MAX_MIN = 59;

  typedef struct packed {
    logic [ORE_W-1:0] ore;
    logic [MIN_W-1:0] minute;
  } timp_t;

  // One-minute advance. Limits are compared with >= so an out-of-range
  // value loaded raw rolls over on its first increment instead of
  // counting up to the field width.
  function automatic timp_t timp_inc(timp_t t);
    timp_t n;
    n = t;
    if (t.minute >= MIN_W'(MAX_MIN)) begin
      n.minute = '0;
      if (t.ore >= ORE_W'(MAX_ORE)) n.ore = '0;
      else                          n.ore = t.ore + 1'b1;
    end else begin
      n.minute = t.minute + 1'b1;
    end
    return n;
  endfunction

  // True when both fields are inside a real time of day.
  function automatic logic timp_valid(timp_t t);
    return (t.ore <= ORE_W'(MAX_ORE)) && (t.minute <= MIN_W'(MAX_MIN));
  endfunction

endpackage

// File: rtl/counter_timp_tick.sv
// counter_timp_tick: minute prescaler. Counts 0..TICKS_PER_MIN-1 and
// raises o_tick for the cycle on which the count wraps. i_clear restarts
// the count and suppresses that cycle's tick.
module counter_timp_tick #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MIN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // With TICKS_PER_MIN=1 the count is pinned at 0, so w_last is always set.
  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last && !i_clear;

  // Prescaler: clear wins over wrap, wrap resets to 0, otherwise count up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_cnt <= '0;
    else if (i_clear || w_last) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/counter_timp.sv
// counter_timp: registered HH:MM time-of-day counter with two presets.
// Priority per edge: reset, load_1, load_2, minute tick.
// Optional build macro COUNTER_TIMP_RANGE_CHECK_EN: presets with hours
// above 23 or minutes above 59 are refused (time and prescaler untouched),
// letting a valid load_2 through when load_1 is refused.
module counter_timp
  import counter_timp_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ORE_W-1:0] timp_ore1,
  input  logic [MIN_W-1:0] timp_minute1,
  input  logic [ORE_W-1:0] timp_ore2,
  input  logic [MIN_W-1:0] timp_minute2,
  input  logic             load_1,
  input  logic             load_2,
  output logic [ORE_W-1:0] out_ore,
  output logic [MIN_W-1:0] out_minute
);

  timp_t w_p1;
  timp_t w_p2;
  timp_t w_sel;
  timp_t r_time;
  logic  w_ld1;
  logic  w_ld2;
  logic  w_load;
  logic  w_tick;

  assign w_p1 = '{ore: timp_ore1, minute: timp_minute1};
  assign w_p2 = '{ore: timp_ore2, minute: timp_minute2};

`ifdef COUNTER_TIMP_RANGE_CHECK_EN
  // A refused preset behaves as if its load were low.
  assign w_ld1 = load_1 && timp_valid(w_p1);
  assign w_ld2 = load_2 && timp_valid(w_p2);
`else
  assign w_ld1 = load_1;
  assign w_ld2 = load_2;
`endif

  assign w_load = w_ld1 || w_ld2;
  assign w_sel  = w_ld1 ? w_p1 : w_p2;

  // Any accepted load restarts the minute so the first increment lands a
  // full TICKS_PER_MIN edges after it.
  counter_timp_tick #(
    .TICKS_PER_MIN(TICKS_PER_MIN)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_load),
    .o_tick (w_tick)
  );

  // Time register: load beats tick; a held load keeps reloading.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_time <= '0;
    else if (w_load) r_time <= w_sel;
    else if (w_tick) r_time <= timp_inc(r_time);
  end

  assign out_ore    = r_time.ore;
  assign out_minute = r_time.minute;

endmodule

// File: tb/tb_counter_timp.sv
// tb_counter_timp: directed vectors with hand-computed HH:MM results.
// The stimulus side queues the value expected after each edge; a monitor
// pops and compares after every rising edge and after async reset.
module tb_counter_timp;
  import counter_timp_pkg::*;

  localparam int TPM = 2;

  typedef struct {
    int    ore;
    int    mn;
    string tag;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [ORE_W-1:0] timp_ore1, timp_ore2;
  logic [MIN_W-1:0] timp_minute1, timp_minute2;
  logic             load_1, load_2;
  logic [ORE_W-1:0] out_ore;
  logic [MIN_W-1:0] out_minute;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  counter_timp #(.TICKS_PER_MIN(TPM)) dut (
    .clock       (clock),
    .reset       (reset),
    .timp_ore1   (timp_ore1),
    .timp_minute1(timp_minute1),
    .timp_ore2   (timp_ore2),
    .timp_minute2(timp_minute2),
    .load_1      (load_1),
    .load_2      (load_2),
    .out_ore     (out_ore),
    .out_minute  (out_minute)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input int o, input int m, input string tag);
    exp_t e;
    e.ore = o; e.mn = m; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Drive one edge's inputs at the falling edge, queue the result after
  // the following rising edge.
  task automatic step(input logic r, input logic l1, input logic l2,
                      input int o, input int m, input string tag);
    @(negedge clock);
    reset  = r;
    load_1 = l1;
    load_2 = l2;
    push(o, m, tag);
  endtask

  task automatic presets(input int o1, input int m1, input int o2, input int m2);
    timp_ore1    = ORE_W'(o1);
    timp_minute1 = MIN_W'(m1);
    timp_ore2    = ORE_W'(o2);
    timp_minute2 = MIN_W'(m2);
  endtask

  // Monitor: after each rising edge or reset assertion, check what is queued.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      #1;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_total++;
        if (int'(out_ore) == e.ore && int'(out_minute) == e.mn) n_pass++;
        else $display("FAIL %s: got %0d:%0d want %0d:%0d",
                      e.tag, out_ore, out_minute, e.ore, e.mn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    load_1 = 1'b1;
    load_2 = 1'b1;
    presets(12, 35, 7, 10);

    // Reset held with both loads active.
    step(0, 1, 1, 0, 0, "rst_hold0");
    step(0, 1, 1, 0, 0, "rst_hold1");
    step(0, 1, 1, 0, 0, "rst_hold2");
    // Release: first increment TPM edges later.
    step(1, 0, 0, 0, 0, "rel_e1");
    step(1, 0, 0, 0, 1, "rel_e2");
    step(1, 0, 0, 0, 1, "rel_e3");
    step(1, 0, 0, 0, 2, "rel_e4");

    // Load 1 pulse.
    step(1, 1, 0, 12, 35, "ld1");
    step(1, 0, 0, 12, 35, "ld1_p1");
    step(1, 0, 0, 12, 36, "ld1_p2");
    // Held load freezes the time.
    step(1, 1, 0, 12, 35, "hold0");
    step(1, 1, 0, 12, 35, "hold1");
    step(1, 1, 0, 12, 35, "hold2");
    step(1, 0, 0, 12, 35, "hold_rel1");
    step(1, 0, 0, 12, 36, "hold_rel2");

    // Simultaneous loads, then load_2 alone.
    step(1, 1, 1, 12, 35, "both");
    step(1, 0, 1, 7, 10, "ld2");
    step(1, 0, 0, 7, 10, "ld2_p1");
    step(1, 0, 0, 7, 11, "ld2_p2");

    // Day wrap and hour carry.
    presets(23, 59, 10, 59);
    step(1, 1, 0, 23, 59, "ld_2359");
    step(1, 0, 0, 23, 59, "w_2359");
    step(1, 0, 0, 0, 0, "wrap_0000");
    step(1, 0, 1, 10, 59, "ld_1059");
    step(1, 0, 0, 10, 59, "w_1059");
    step(1, 0, 0, 11, 0, "carry_1100");

    // Out-of-range presets.
    presets(24, 0, 5, 0);
    step(1, 0, 1, 5, 0, "ld_0500");
`ifdef COUNTER_TIMP_RANGE_CHECK_EN
    step(1, 1, 0, 5, 0, "rej_2400");
    step(1, 0, 0, 5, 1, "rej_cont");
    presets(24, 0, 8, 15);
    step(1, 1, 1, 8, 15, "bad1_ok2");
    step(1, 0, 0, 8, 15, "b12_p1");
    step(1, 0, 0, 8, 16, "b12_p2");
    presets(10, 60, 8, 15);
    step(1, 1, 0, 8, 16, "rej_1060");
    step(1, 0, 0, 8, 17, "rej_tick");
    presets(24, 59, 8, 15);
    step(1, 1, 0, 8, 17, "rej_2459");
    step(1, 0, 0, 8, 18, "rej_tick2");
`else
    step(1, 1, 0, 24, 0, "raw_2400");
    step(1, 0, 0, 24, 0, "raw_p1");
    step(1, 0, 0, 24, 1, "raw_2401");
    presets(24, 0, 8, 15);
    step(1, 1, 1, 24, 0, "raw_both");
    step(1, 0, 0, 24, 0, "rb_p1");
    step(1, 0, 0, 24, 1, "rb_p2");
    presets(10, 60, 8, 15);
    step(1, 1, 0, 10, 60, "raw_1060");
    step(1, 0, 0, 10, 60, "r1060_p1");
    step(1, 0, 0, 11, 0, "fix_1100");
    presets(24, 59, 8, 15);
    step(1, 1, 0, 24, 59, "raw_2459");
    step(1, 0, 0, 24, 59, "r2459_p1");
    step(1, 0, 0, 0, 0, "fix_0000");
`endif

    // Async reset between edges at 12:40.
    presets(12, 40, 8, 15);
    step(1, 1, 0, 12, 40, "ld_1240");
    step(1, 0, 0, 12, 40, "c_1240");
    @(posedge clock);
    #3;
    push(0, 0, "async_rst");
    reset = 1'b0;
    step(0, 0, 0, 0, 0, "rst_mid");
    step(1, 0, 0, 0, 0, "rel2_e1");
    step(1, 0, 0, 0, 1, "rel2_e2");

    @(negedge clock);
    @(negedge clock);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
